// File: rtl/dsp_add_arbiter_if.sv
// Request/response bundle for the shared 32-bit adder: NUM_REQ packed requester
// lanes on one side, a single result stream on the other.
interface dsp_add_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_sum;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, busy
    );
endinterface

// File: rtl/dsp_add_arbiter.sv
// Round-robin arbiter sharing one 32-bit DSP adder between NUM_REQ requesters,
// with an operand register stage and a back-pressured result register stage.
module dsp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input logic              clk,
    input logic              reset,
    dsp_add_arbiter_if.slave arb
);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [31:0]     s1_a_q, s1_a_d;
    logic [31:0]     s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_sum_q, rsp_sum_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic               out_free, s1_free, any_req, xfer;
    logic [NUM_REQ-1:0] rot_valid, rot_first, gnt_oh;
    logic [ID_W-1:0]    gnt_idx;
    logic [31:0]        sel_a, sel_b;

    // Rotate so bit 0 is the requester at ptr, pick the lowest set bit, rotate back.
    assign rot_valid = NUM_REQ'({arb.req_valid, arb.req_valid} >> ptr_q);
    assign rot_first = rot_valid & (~rot_valid + NUM_REQ'(1));
    assign gnt_oh    = NUM_REQ'(({rot_first, rot_first} << ptr_q) >> NUM_REQ);
    assign any_req   = |rot_valid;

    logic [31:0]     a_acc  [NUM_REQ+1];
    logic [31:0]     b_acc  [NUM_REQ+1];
    logic [ID_W-1:0] id_acc [NUM_REQ+1];

    assign a_acc[0]  = '0;
    assign b_acc[0]  = '0;
    assign id_acc[0] = '0;

    // One-hot AND-OR select of the granted lane's operands and index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign a_acc[gi+1]  = a_acc[gi]  | ({32{gnt_oh[gi]}} & arb.req_a[32*gi +: 32]);
            assign b_acc[gi+1]  = b_acc[gi]  | ({32{gnt_oh[gi]}} & arb.req_b[32*gi +: 32]);
            assign id_acc[gi+1] = id_acc[gi] | (gnt_oh[gi] ? ID_W'(gi) : '0);
        end
    endgenerate

    assign sel_a   = a_acc[NUM_REQ];
    assign sel_b   = b_acc[NUM_REQ];
    assign gnt_idx = id_acc[NUM_REQ];

    assign out_free = !rsp_valid_q || arb.rsp_ready;
    assign s1_free  = !s1_valid_q || out_free;
    assign xfer     = s1_free && any_req && !reset;

    assign arb.req_ready = (s1_free && !reset) ? gnt_oh : '0;

    // Adder split as the DSP sees it: s1_a on A:B, s1_b on C:D, carry across halves.
    logic [16:0] add_lo;
    logic [15:0] add_hi;
    logic [31:0] add_sum;

    assign add_lo  = {1'b0, s1_a_q[15:0]} + {1'b0, s1_b_q[15:0]};
    assign add_hi  = s1_a_q[31:16] + s1_b_q[31:16] + {15'd0, add_lo[16]};
    assign add_sum = {add_hi, add_lo[15:0]};

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;

        if (xfer) begin
            s1_valid_d = 1'b1;
            s1_a_d     = sel_a;
            s1_b_d     = sel_b;
            s1_id_d    = gnt_idx;
            ptr_d      = (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
        end else if (out_free) begin
            s1_valid_d = 1'b0;
        end

        if (out_free && s1_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_sum_d   = add_sum;
            rsp_id_d    = s1_id_q;
        end else if (arb.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign arb.rsp_valid = rsp_valid_q;
    assign arb.rsp_sum   = rsp_sum_q;
    assign arb.rsp_id    = rsp_id_q;
    assign arb.busy      = s1_valid_q || rsp_valid_q;
endmodule

// File: tb/tb_dsp_add_arbiter.sv
// Randomised bench for dsp_add_arbiter: a round-robin/capacity-2 reference model
// predicts grants and results into a queue, a monitor drains and compares it.
module tb_dsp_add_arbiter;
    localparam int NR = 4;
    localparam int IW = 2;

    logic clk;
    logic reset;

    dsp_add_arbiter_if #(.NUM_REQ(NR), .ID_W(IW)) bus ();

    dsp_add_arbiter #(.NUM_REQ(NR), .ID_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] id;
        logic [31:0]   sum;
        int            acc_edge;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            ptr_m = 0;
    logic [NR-1:0] last_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    always @(posedge clk) if (!reset) cyc <= cyc + 1;

    // Monitor: result visible once its accept edge is behind us; pops on handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        end else begin
            logic vis;
            vis = (exp_q.size() > 0) && (exp_q[0].acc_edge < cyc);
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, vis});
            chk("busy", {31'd0, bus.busy}, {31'd0, exp_q.size() > 0});
            if (vis && bus.rsp_valid && bus.rsp_ready) begin
                chk("rsp_id", {30'd0, bus.rsp_id}, {30'd0, exp_q[0].id});
                chk("rsp_sum", bus.rsp_sum, exp_q[0].sum);
                $display("rsp id=%0d sum=%h", bus.rsp_id, bus.rsp_sum);
                void'(exp_q.pop_front());
            end
        end
    end

    // Predictor: two results may be in flight; a third only if the oldest drains now.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            ptr_m = 0;
            chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        end else begin
            logic [NR-1:0] eg;
            int            gi;
            eg = '0;
            gi = -1;
            if (exp_q.size() < 2) begin
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (ptr_m + k) % NR;
                    if (gi < 0 && bus.req_valid[idx]) gi = idx;
                end
            end
            if (gi >= 0) eg[gi] = 1'b1;
            chk("req_ready", {28'd0, bus.req_ready}, {28'd0, eg});
            if (gi >= 0) begin
                exp_t e;
                e.id       = IW'(gi);
                e.sum      = bus.req_a[32*gi +: 32] + bus.req_b[32*gi +: 32];
                e.acc_edge = cyc + 1;
                exp_q.push_back(e);
                ptr_m = (gi + 1) % NR;
                $display("grant id=%0d a=%h b=%h", gi, bus.req_a[32*gi +: 32], bus.req_b[32*gi +: 32]);
            end
        end
    end

    // One clock of stimulus: retire accepted requests, maybe raise new ones.
    task automatic cycle(input int pv, input int pr, input logic [NR-1:0] mask);
        @(negedge clk);
        #2;
        last_acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #2;
        for (int i = 0; i < NR; i++) begin
            if (last_acc[i]) bus.req_valid[i] = 1'b0;
            if (!bus.req_valid[i] && mask[i] && ($urandom_range(99) < pv)) begin
                bus.req_valid[i]        = 1'b1;
                bus.req_a[32*i +: 32]   = rnd();
                bus.req_b[32*i +: 32]   = rnd();
            end
        end
        bus.rsp_ready = ($urandom_range(99) < pr);
    endtask

    task automatic send(input int i, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid[i]      = 1'b1;
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        last_acc = '0;
        for (int t = 0; t < 20 && !last_acc[i]; t++) cycle(0, 100, '0);
        if (!last_acc[i]) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // Directed single request and wrap-around sums.
        send(0, 32'h0000_FFFF, 32'h0000_0001);
        send(1, 32'hFFFF_FFFF, 32'h0000_0002);
        send(2, 32'h8000_0000, 32'h8000_0000);
        repeat (4) cycle(0, 100, '0);

        // All requesters held busy: strict rotation, one result per cycle.
        repeat (40) cycle(100, 100, '1);

        // Back-pressure then release.
        repeat (5) cycle(100, 0, '1);
        repeat (10) cycle(100, 100, '1);
        repeat (6) cycle(0, 100, '0);

        // Requester 0 streaming, requester 2 joins later.
        repeat (4) cycle(100, 100, 4'b0001);
        repeat (6) cycle(100, 100, 4'b0101);
        repeat (6) cycle(0, 100, '0);

        // Random traffic with random consumer stalls.
        repeat (800) cycle(60, 70, '1);

        // Fill both stages, then reset asynchronously mid-cycle.
        repeat (4) cycle(100, 0, '1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 4'b1010;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[32*i +: 32] = rnd();
            bus.req_b[32*i +: 32] = rnd();
        end
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (8) cycle(0, 100, '0);

        chk("drain_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dsp_add_arbiter.md
Name: dsp_add_arbiter

Overview:
- Shares one 32-bit DSP adder instance (SB_MAC16 in combinational 32-bit add mode) between NUM_REQ requesters, e.g. the ALU, the branch-target unit and the address generator.
- Round-robin arbitration with a per-requester valid/ready handshake.
- Two-stage pipeline: a registered operand stage feeds the adder, and a registered result stage has a single-entry output hold for back-pressure.
- Throughput is one add per cycle when the consumer is not stalling.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ), 1 when NUM_REQ=2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  32*NUM_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, packed the same way.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns rsp_sum.
- rsp_sum  out  32  (a+b) mod 2^32.
- busy  out  1  s1_valid | rsp_valid.

Behaviour:
- Reset (asynchronous, active-high) clears: s1_valid=0, s1_a=0, s1_b=0, s1_id=0, rsp_valid=0, rsp_sum=0, rsp_id=0, ptr=0.
  - While reset is high, req_ready is forced to 0.
  - Reset mid-operation discards all in-flight operations; no response is produced for them.
- Handshake:
  - Transfer on requester i occurs when req_valid[i] && req_ready[i] at a rising edge.
  - Requesters hold req_valid, req_a and req_b stable until accepted; req_valid must not depend on req_ready.
  - req_ready is combinational from req_valid, ptr and the stall condition.
- Advance conditions:
  - out_free = !rsp_valid | rsp_ready.
  - s1_free = !s1_valid | out_free.
  - If s1_free=0, all req_ready bits are 0.
- Arbitration (stage 0):
  - When s1_free=1, grant the first i with req_valid[i]=1, searching ptr, ptr+1, ... NUM_REQ-1, 0, ... ptr-1.
  - On a grant to i, ptr <= (i+1) mod NUM_REQ.
  - ptr is unchanged when no transfer occurs.
  - No starvation: a held request waits at most NUM_REQ-1 grants to other requesters.
- Stage 1 (operand registers):
  - On a transfer, s1_a/s1_b/s1_id <= the selected operands and index, and s1_valid <= 1.
  - Else, if out_free, s1_valid <= 0.
  - Else the stage holds.
  - The adder instance sees s1_a on its upper/lower halves (A,B) and s1_b on (C,D); its output is combinational.
- Stage 2 (result):
  - If out_free and s1_valid: rsp_sum <= adder output, rsp_id <= s1_id, rsp_valid <= 1.
  - Else, if rsp_ready: rsp_valid <= 0.
  - While rsp_valid && !rsp_ready, rsp_sum and rsp_id are held stable.
- Latency: accepted at edge T → rsp_valid=1 after edge T+1 (two edges), absent stall.
- Arithmetic: unsigned 32-bit wrap-around. Carry-out is discarded; no signed or overflow flag.
- Simultaneous events:
  - A result draining and a new result loading in the same edge is legal; rsp_valid stays 1 with the new data.
  - Stage 1 refilling in the same edge it drains is legal.
- Stall: with both stages full and rsp_ready=0, no new grant is issued. Stall release: the first edge with rsp_ready=1 moves stage 1 to stage 2, and a grant may be issued in that same cycle.
- No response is dropped, duplicated or reordered: responses appear in grant order.

Test Plan:
- Single request: req_valid=0001, a=0x0000FFFF, b=0x00000001 → req_ready=0001 for one cycle; two edges later rsp_valid=1, rsp_id=0, rsp_sum=0x00010000.
- Wrap-around: a=0xFFFFFFFF, b=0x00000002 → rsp_sum=0x00000001; a=0x80000000, b=0x80000000 → rsp_sum=0x00000000.
- Round robin: all four req_valid held high from reset, rsp_ready=1 → grant order 0,1,2,3,0,...; one response per cycle; rsp_id follows the same order; ptr wraps 3→0.
- Back-pressure: rsp_ready=0 for 5 cycles with requests pending → rsp_sum/rsp_id stable, s1 holds, req_ready=0000. After rsp_ready=1, results emerge in order with no loss or duplication.
- Fairness: requester 0 always valid, requester 2 asserts valid mid-stream → requester 2 is granted within 2 grants; ptr=3 afterwards.
- Reset mid-operation: assert reset with both stages full → rsp_valid, busy and req_ready drop immediately (asynchronously). After release, no stale response appears, and the first grant goes to the lowest valid index (ptr=0).
